// File: rtl/pwm_compare.sv
// ---------------------------------------------------------------------------
// pwm_compare
//
// Compares the value of a free-running 8-bit up-counter against a
// double-buffered duty register. It drives a registered PWM output, its
// complement and a one-cycle period-start tick.
//
// A new duty value arrives over a valid/ready handshake and is held in a
// shadow register. It moves into the active register only at the next counter
// wrap, so an output period is never built from two different duty values.
//
// Optional feature, selected by the macro PWM_DEADTIME_EN:
//   With the macro defined, pwm_out and pwm_n come from a four-state
//   dead-time FSM (OFF, DT_RISE, ON, DT_FALL). Each high pulse is shortened by
//   DEADTIME cycles, and the two outputs are never high in the same cycle.
//   With the macro undefined, pwm_n is the complement of pwm_out. The only
//   exception is reset, where both outputs are 0.
//
// Parameters:
//   DEADTIME    dead-time length in clk cycles, 1..15 (dead-time build only)
//   RESET_DUTY  duty loaded into the active and shadow registers on reset
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   synchronous reset, active-high
//   count  [7:0] in   upstream counter value, same clock domain
//   duty_in[7:0] in   new duty value
//   duty_valid   in   duty_in is valid this cycle
//   duty_ready   out  a duty value can be accepted this cycle
//   pwm_out      out  primary PWM output, registered
//   pwm_n        out  complementary PWM output, registered
//   period_tick  out  pulse on the first output cycle of each period
//   duty_active  out  duty value currently applied
// ---------------------------------------------------------------------------
module pwm_compare #(
    parameter int unsigned DEADTIME   = 4,
    parameter logic [7:0]  RESET_DUTY = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] count,
    input  logic [7:0] duty_in,
    input  logic       duty_valid,
    output logic       duty_ready,
    output logic       pwm_out,
    output logic       pwm_n,
    output logic       period_tick,
    output logic [7:0] duty_active
);

    // Handshake states
    localparam logic HS_EMPTY   = 1'b0;
    localparam logic HS_PENDING = 1'b1;

    logic [7:0] prev_count_q;
    logic       hs_state_q, hs_state_d;
    logic [7:0] active_q,   active_d;
    logic [7:0] shadow_q,   shadow_d;
    logic       pwm_out_q,  pwm_out_d;
    logic       pwm_n_q,    pwm_n_d;
    logic       period_tick_q;

    logic       ps;
    logic       accept;
    logic [7:0] eff_duty;
    logic       cmp;

    // -----------------------------------------------------------------------
    // Period start
    // -----------------------------------------------------------------------
    // A period starts on the first cycle with count == 0. prev_count resets
    // to 8'hFF, so the first zero after reset also counts as a period start.
    // If the upstream counter is held in reset, count stays at 0 for several
    // cycles; this rule still gives only one period start for that stretch.
    assign ps = (count == 8'h00) && (prev_count_q != 8'h00);

    // -----------------------------------------------------------------------
    // Duty handshake
    // -----------------------------------------------------------------------
    assign duty_ready = (hs_state_q == HS_EMPTY) && !rst;
    assign accept     = duty_valid && duty_ready;

    always_comb begin
        // NOTE: every signal gets its hold value before the branches, so no
        // path through this block can leave it unassigned and infer a latch.
        hs_state_d = hs_state_q;
        active_d   = active_q;
        shadow_d   = shadow_q;
        if (hs_state_q == HS_PENDING) begin
            if (ps) begin
                active_d   = shadow_q;
                hs_state_d = HS_EMPTY;
            end
        end else if (accept) begin
            // A value accepted in a period-start cycle waits for the next
            // period start. The consume branch above requires PENDING, and
            // the state was EMPTY in this cycle.
            shadow_d   = duty_in;
            hs_state_d = HS_PENDING;
        end
    end

    // -----------------------------------------------------------------------
    // Compare
    // -----------------------------------------------------------------------
    // In the period-start cycle that consumes a pending value, active_q still
    // holds the old duty. The compare therefore takes the shadow value in that
    // cycle, so period_tick lines up with the first output of the new duty.
    assign eff_duty = (ps && (hs_state_q == HS_PENDING)) ? shadow_q : active_q;
    // An unsigned compare gives at most 255 high cycles per 256-cycle period.
    // A 100% duty is intentionally unreachable.
    assign cmp      = (count < eff_duty);

`ifdef PWM_DEADTIME_EN
    // -----------------------------------------------------------------------
    // Dead-time FSM
    // -----------------------------------------------------------------------
    localparam logic [1:0] DT_OFF  = 2'd0;
    localparam logic [1:0] DT_RISE = 2'd1;
    localparam logic [1:0] DT_ON   = 2'd2;
    localparam logic [1:0] DT_FALL = 2'd3;

    // The timer counts down to zero. The state then leaves DT_RISE/DT_FALL
    // on the next edge, which gives exactly DEADTIME cycles in each dead zone.
    localparam logic [3:0] DT_LOAD = 4'(DEADTIME - 1);

    logic [1:0] dt_state_q, dt_state_d;
    logic [3:0] dt_timer_q, dt_timer_d;

    always_comb begin
        dt_state_d = dt_state_q;
        dt_timer_d = dt_timer_q;
        case (dt_state_q)
            DT_OFF: begin
                if (cmp) begin
                    dt_state_d = DT_RISE;
                    dt_timer_d = DT_LOAD;
                end
            end
            DT_RISE: begin
                if (!cmp) begin
                    // A pulse no longer than DEADTIME never reaches ON.
                    dt_state_d = DT_OFF;
                end else if (dt_timer_q == 4'd0) begin
                    dt_state_d = DT_ON;
                end else begin
                    dt_timer_d = dt_timer_q - 4'd1;
                end
            end
            DT_ON: begin
                if (!cmp) begin
                    dt_state_d = DT_FALL;
                    dt_timer_d = DT_LOAD;
                end
            end
            DT_FALL: begin
                if (cmp) begin
                    dt_state_d = DT_ON;
                end else if (dt_timer_q == 4'd0) begin
                    dt_state_d = DT_OFF;
                end else begin
                    dt_timer_d = dt_timer_q - 4'd1;
                end
            end
            default: begin
                dt_state_d = DT_OFF;
            end
        endcase
    end

    // The outputs are decoded from the next state and then registered. This
    // keeps the count-to-output latency at one cycle and avoids glitches.
    always_comb begin
        pwm_out_d = (dt_state_d == DT_ON);
        pwm_n_d   = (dt_state_d == DT_OFF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dt_state_q <= DT_OFF;
            dt_timer_q <= 4'd0;
        end else begin
            dt_state_q <= dt_state_d;
            dt_timer_q <= dt_timer_d;
        end
    end
`else
    always_comb begin
        pwm_out_d = cmp;
        pwm_n_d   = ~cmp;
    end
`endif

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments. Every register
        // then samples the values from before the edge, whatever the order of
        // the statements in this block.
        if (rst) begin
            prev_count_q  <= 8'hFF;
            hs_state_q    <= HS_EMPTY;
            active_q      <= RESET_DUTY;
            shadow_q      <= RESET_DUTY;
            pwm_out_q     <= 1'b0;
            pwm_n_q       <= 1'b0;
            period_tick_q <= 1'b0;
        end else begin
            prev_count_q  <= count;
            hs_state_q    <= hs_state_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            pwm_out_q     <= pwm_out_d;
            pwm_n_q       <= pwm_n_d;
            period_tick_q <= ps;
        end
    end

    assign pwm_out     = pwm_out_q;
    assign pwm_n       = pwm_n_q;
    assign period_tick = period_tick_q;
    assign duty_active = active_q;

endmodule

// File: tb/tb_pwm_compare.sv
// ---------------------------------------------------------------------------
// tb_pwm_compare
//
// Directed bench for pwm_compare.
//
// The first part is a table of single-cycle vectors. These cover reset, the
// handshake, the compare, non-monotonic counts and the period-start rule.
//
// The second part is a set of full 256-cycle periods. These check duty
// lengths, extreme duties, the hold-off of a pending value and the case where
// an accept and a period start fall in the same cycle.
//
// With PWM_DEADTIME_EN defined, the bench runs the dead-time period checks
// instead.
// ---------------------------------------------------------------------------
module tb_pwm_compare;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] count;
    logic [7:0] duty_in;
    logic       duty_valid;
    logic       duty_ready;
    logic       pwm_out;
    logic       pwm_n;
    logic       period_tick;
    logic [7:0] duty_active;

    always #5 clk = ~clk;

    pwm_compare #(
        .DEADTIME   (4),
        .RESET_DUTY (8'h5A)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .count       (count),
        .duty_in     (duty_in),
        .duty_valid  (duty_valid),
        .duty_ready  (duty_ready),
        .pwm_out     (pwm_out),
        .pwm_n       (pwm_n),
        .period_tick (period_tick),
        .duty_active (duty_active)
    );

    int   n_vec = 0;
    int   n_err = 0;
    logic rdy_pre;

    // Per-period statistics, filled in by run_period
    int   hi_cnt, n_cnt, both_hi, both_lo, tick_cnt, late_ready;
    logic hi_first, hi_last;

    typedef struct packed {
        logic       rst;
        logic [7:0] count;
        logic [7:0] din;
        logic       dv;
        logic       ready;   // duty_ready before the edge
        logic       pwm;     // outputs after the edge
        logic       pwm_n;
        logic       tick;
        logic [7:0] act;
    } vec_t;

    vec_t tbl [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drives one cycle of inputs. duty_ready is sampled before the edge and
    // the registered outputs 1 ns after it.
    task automatic cyc(input logic r, input logic [7:0] c, input logic [7:0] d, input logic v);
        rst        = r;
        count      = c;
        duty_in    = d;
        duty_valid = v;
        #1;
        rdy_pre = duty_ready;
        @(posedge clk);
        #1;
    endtask

    // Runs count from 0 to 255. duty_valid can be raised at up to two counts.
    task automatic run_period(input logic [7:0] at_a, input logic [7:0] din_a, input logic en_a,
                              input logic [7:0] at_b, input logic [7:0] din_b, input logic en_b);
        logic [7:0] c, d;
        logic       v;
        hi_cnt = 0; n_cnt = 0; both_hi = 0; both_lo = 0; tick_cnt = 0; late_ready = 0;
        hi_first = 1'b0; hi_last = 1'b0;
        for (int i = 0; i < 256; i++) begin
            c = 8'(i);
            v = 1'b0;
            d = 8'd0;
            if (en_a && c == at_a) begin v = 1'b1; d = din_a; end
            if (en_b && c == at_b) begin v = 1'b1; d = din_b; end
            cyc(1'b0, c, d, v);
            if (pwm_out)             hi_cnt++;
            if (pwm_n)               n_cnt++;
            if (pwm_out && pwm_n)    both_hi++;
            if (!pwm_out && !pwm_n)  both_lo++;
            if (period_tick)         tick_cnt++;
            if (c > at_a && rdy_pre) late_ready++;
            if (i == 0)   hi_first = pwm_out;
            if (i == 255) hi_last  = pwm_out;
        end
    endtask

    initial begin
        // rst, count, din, dv | ready, pwm, pwm_n, tick, active
        tbl[0]  = '{1'b0, 8'd0,   8'd0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd90};
        tbl[1]  = '{1'b0, 8'd1,   8'd10,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd90};
        tbl[2]  = '{1'b0, 8'd2,   8'd99,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd90};
        tbl[3]  = '{1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd10};
        tbl[4]  = '{1'b0, 8'd0,   8'd0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd10};
        tbl[5]  = '{1'b0, 8'd9,   8'd0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd10};
        tbl[6]  = '{1'b0, 8'd10,  8'd0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd10};
        tbl[7]  = '{1'b0, 8'd255, 8'd255, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd10};
        tbl[8]  = '{1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd255};
        tbl[9]  = '{1'b0, 8'd254, 8'd0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd255};
        tbl[10] = '{1'b0, 8'd255, 8'd0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd255};
        tbl[11] = '{1'b0, 8'd0,   8'd32,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd255};
        tbl[12] = '{1'b0, 8'd40,  8'd7,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd255};
        tbl[13] = '{1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd32};
        tbl[14] = '{1'b0, 8'd32,  8'd0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd32};
        tbl[15] = '{1'b0, 8'd31,  8'd200, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd32};
        tbl[16] = '{1'b1, 8'd5,   8'd77,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd90};
        tbl[17] = '{1'b0, 8'd0,   8'd0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd90};

        // Reset held for 3 cycles while count runs
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'(i), 8'd0, 1'b0);
            check($sformatf("reset[%0d] duty_ready", i), 32'(rdy_pre), 32'd0);
            check($sformatf("reset[%0d] pwm_out", i), 32'(pwm_out), 32'd0);
            check($sformatf("reset[%0d] pwm_n", i), 32'(pwm_n), 32'd0);
            check($sformatf("reset[%0d] period_tick", i), 32'(period_tick), 32'd0);
        end
        check("reset duty_active", 32'(duty_active), 32'h5A);

`ifndef PWM_DEADTIME_EN
        // Single-cycle vector table
        for (int k = 0; k < 18; k++) begin
            cyc(tbl[k].rst, tbl[k].count, tbl[k].din, tbl[k].dv);
            check($sformatf("vec%0d duty_ready", k), 32'(rdy_pre), 32'(tbl[k].ready));
            check($sformatf("vec%0d pwm_out", k), 32'(pwm_out), 32'(tbl[k].pwm));
            check($sformatf("vec%0d pwm_n", k), 32'(pwm_n), 32'(tbl[k].pwm_n));
            check($sformatf("vec%0d period_tick", k), 32'(period_tick), 32'(tbl[k].tick));
            check($sformatf("vec%0d duty_active", k), 32'(duty_active), 32'(tbl[k].act));
        end

        // Basic duty of 64
        cyc(1'b0, 8'd200, 8'd64, 1'b1);
        check("load64 accepted ready", 32'(rdy_pre), 32'd1);
        run_period(8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0);
        check("duty64 high cycles", 32'(hi_cnt), 32'd64);
        check("duty64 pwm_n cycles", 32'(n_cnt), 32'd192);
        check("duty64 ticks", 32'(tick_cnt), 32'd1);
        check("duty64 first sample high", 32'(hi_first), 32'd1);
        check("duty64 active", 32'(duty_active), 32'd64);

        // Accept 100 at count 10; a second valid at count 20 is ignored
        run_period(8'd10, 8'd100, 1'b1, 8'd20, 8'd7, 1'b1);
        check("hs period keeps old duty", 32'(hi_cnt), 32'd64);
        check("hs ready low until wrap", 32'(late_ready), 32'd0);
        check("hs active before wrap", 32'(duty_active), 32'd64);
        run_period(8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0);
        check("hs next period duty", 32'(hi_cnt), 32'd100);
        check("hs next period ticks", 32'(tick_cnt), 32'd1);
        check("hs active after wrap", 32'(duty_active), 32'd100);

        // Accept 32 in the same cycle as the period start
        run_period(8'd0, 8'd32, 1'b1, 8'd0, 8'd0, 1'b0);
        check("simul period keeps old duty", 32'(hi_cnt), 32'd100);
        check("simul ready low after accept", 32'(late_ready), 32'd0);
        run_period(8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0);
        check("simul next period duty", 32'(hi_cnt), 32'd32);
        check("simul active", 32'(duty_active), 32'd32);

        // Extremes
        cyc(1'b0, 8'd200, 8'd0, 1'b1);
        run_period(8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0);
        check("duty0 high cycles", 32'(hi_cnt), 32'd0);
        check("duty0 pwm_n cycles", 32'(n_cnt), 32'd256);
        cyc(1'b0, 8'd200, 8'd255, 1'b1);
        run_period(8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0);
        check("duty255 high cycles", 32'(hi_cnt), 32'd255);
        check("duty255 low at count 255", 32'(hi_last), 32'd0);
        check("duty255 high at count 0", 32'(hi_first), 32'd1);
`else
        // Dead time of 4 with duty 64
        cyc(1'b0, 8'd200, 8'd64, 1'b1);
        check("load64 accepted ready", 32'(rdy_pre), 32'd1);
        run_period(8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0);
        check("dt duty64 high cycles", 32'(hi_cnt), 32'd60);
        check("dt duty64 pwm_n cycles", 32'(n_cnt), 32'd188);
        check("dt duty64 both high", 32'(both_hi), 32'd0);
        check("dt duty64 both low", 32'(both_lo), 32'd8);
        check("dt duty64 ticks", 32'(tick_cnt), 32'd1);

        // A duty of 3 is shorter than the dead time and is suppressed
        cyc(1'b0, 8'd200, 8'd3, 1'b1);
        run_period(8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0);
        check("dt duty3 high cycles", 32'(hi_cnt), 32'd0);
        check("dt duty3 both high", 32'(both_hi), 32'd0);
        check("dt duty3 active", 32'(duty_active), 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_compare.md
# pwm_compare

Downstream consumer of the free-running 8-bit up-counter: compares the counter value against a double-buffered duty register and produces a registered PWM output, a complementary output, and a period-start tick. New duty values arrive over a valid/ready handshake and take effect only at the next counter wrap, so output periods are never torn. Sits between the counter and the pad/driver logic.

## Interface
- `DEADTIME`, default 4: dead-time length in clk cycles, legal range 1..15. Used only when `PWM_DEADTIME_EN` is defined.
- `RESET_DUTY`, default 8'h00: duty value loaded into the active and shadow registers at reset.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `count`  in  8  counter value from the upstream up-counter, same clock domain.
- `duty_in`  in  8  new duty value.
- `duty_valid`  in  1  `duty_in` is valid this cycle.
- `duty_ready`  out  1  block can accept a duty value this cycle.
- `pwm_out`  out  1  primary PWM output, registered.
- `pwm_n`  out  1  complementary PWM output, registered.
- `period_tick`  out  1  one-cycle pulse on the first output cycle of each period.
- `duty_active`  out  8  duty value currently applied.

## Operation
- **Period start (`ps`), combinational:**
  - `ps = (count == 8'h00) && (prev_count != 8'h00)`.
  - `prev_count` is a register that resets to 8'hFF, so the first cycle out of reset with `count == 0` is a period start.
  - Upstream reset holding `count` at 0 gives exactly one `ps`.
- **Duty handshake, two states (EMPTY, PENDING):**
  - `duty_ready = (state == EMPTY) && !rst`.
  - Accept when `duty_valid && duty_ready`: `shadow <= duty_in`, state becomes PENDING.
  - On `ps` while in PENDING: `active <= shadow`, state becomes EMPTY.
  - Accept and `ps` in the same cycle (state was EMPTY): the accepted value waits for the next `ps`.
  - `duty_valid` while not ready: ignored, no side effects.
- **Compare:**
  - `eff_duty = (ps && state == PENDING) ? shadow : active`.
  - `cmp = (count < eff_duty)`, an unsigned 8-bit compare.
  - Duty 0 gives `pwm_out` permanently low. Duty 255 gives 255 high cycles out of 256.
  - There is no 100% duty; this is deliberate.
- **Outputs:**
  - `pwm_out <= cmp`.
  - `pwm_n <= ~cmp` (without the macro).
  - `period_tick <= ps`.
  - `duty_active` reflects the `active` register.
- **Non-monotonic `count`** (for example, upstream reset mid-period):
  - Compare simply follows `count`.
  - `ps` fires per the rule above.
  - No error is flagged.

## Timing
- Latency `count` to `pwm_out`/`pwm_n`/`period_tick` is 1 cycle.
- `period_tick` is high in the same cycle as the first `pwm_out` value computed with the new duty.
- Shortest handshake-to-effect: accept in cycle N where N+1 is `ps`; the new duty shows on `pwm_out` in cycle N+2.
- `duty_ready` drops the cycle after an accept and returns the cycle after the consuming `ps`.
- Reset values, applied in the cycle after `rst` is sampled high:

  | Signal / register | Reset value |
  |---|---|
  | `pwm_out` | 0 |
  | `pwm_n` | 0 |
  | `period_tick` | 0 |
  | `active`, `shadow` | `RESET_DUTY` |
  | handshake state | EMPTY |
  | dead-time FSM | OFF, timer 0 |

- Reset mid-period discards any pending duty value.

## Configuration
- **Macro `PWM_DEADTIME_EN`.**
- **Defined:** `pwm_out`/`pwm_n` are driven by a four-state FSM: OFF, DT_RISE, ON, DT_FALL, with a 4-bit timer.
  - OFF: `pwm_n = 1`, `pwm_out = 0`. `cmp = 1` moves to DT_RISE (timer loaded).
  - DT_RISE: both outputs 0. Stays `DEADTIME` cycles, then goes to ON. If `cmp` falls, returns to OFF immediately.
  - ON: `pwm_out = 1`. `cmp = 0` moves to DT_FALL.
  - DT_FALL: both outputs 0. Stays `DEADTIME` cycles, then goes to OFF. If `cmp` rises, returns to ON.
  - Both outputs are never high in the same cycle.
  - The high pulse is shortened by `DEADTIME`. Pulses of length `DEADTIME` or less are suppressed.
- **Undefined:** FSM and timer are absent; `pwm_n = ~pwm_out` except during reset, where both are 0.

## Test plan
- **Reset:** hold `rst` 3 cycles with `count` running. Expect all outputs 0, `duty_ready = 0`. After release, `duty_ready = 1` and `duty_active = RESET_DUTY`.
- **Basic duty:** load 8'd64 before a wrap, count 0..255. Expect `pwm_out` high for exactly 64 cycles, starting 1 cycle after `count = 0`. `period_tick` is a single pulse.
- **Extremes:** duty 0 gives no high cycles in 256. Duty 255 gives 255 high cycles, low only for the `count = 255` sample.
- **Handshake:**
  - Accept 8'd100 at `count = 10`: `duty_ready` is low until the wrap, and the period keeps the old duty.
  - A second `duty_valid` at `count = 20` is ignored.
  - 8'd100 takes effect on the next period.
- **Simultaneous accept and `ps`:** accept 8'd32 when `count = 0`. The current period uses the old duty; the next period uses 32.
- **Dead time (`PWM_DEADTIME_EN`, `DEADTIME = 4`):**
  - Duty 64 gives `pwm_out` high for 60 cycles, with 4-cycle gaps where both outputs are low at each edge and never both high.
  - Duty 3 gives `pwm_out` never high.
